bm_enc_ctrl: RTL and testbench

BM_ENC_CTRL -- requirements
Module: bm_enc_ctrl

---
 rtl/bm_enc_ctrl.sv | 168 ++++++++++++++++
 tb/tb_bm_enc_ctrl.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bm_enc_ctrl.sv
// Bitmatrix erasure-encode sequencer: fetches a bitmatrix block and a data packet per
// (parity, data) pair, feeds an external GF multiplier and XOR-accumulates each parity packet.
module bm_enc_ctrl #(
    parameter int K_MAX         = 128,
    parameter int K_MIN         = 2,
    parameter int M_MAX         = 128,
    parameter int M_MIN         = 2,
    parameter int W             = 4,
    parameter int PACKET_LENGTH = 2,
    localparam int PW = W * PACKET_LENGTH,
    localparam int KW = $clog2(K_MAX + 1),
    localparam int MW = $clog2(M_MAX + 1),
    localparam int KI = $clog2(K_MAX),
    localparam int MI = $clog2(M_MAX)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [KW-1:0]   k_cfg,
    input  logic [MW-1:0]   m_cfg,
    output logic            busy,
    output logic            done,
    output logic            cfg_err,
    output logic            bm_rd_en,
    output logic [MI-1:0]   bm_rd_row,
    output logic [KI-1:0]   bm_rd_col,
    input  logic [W*W-1:0]  bm_rd_data,
    output logic            data_rd_en,
    output logic [KI-1:0]   data_rd_idx,
    input  logic [PW-1:0]   data_rd_data,
    output logic [W*W-1:0]  mul_cols,
    output logic [PW-1:0]   mul_pkt,
    input  logic [PW-1:0]   mul_product,
    output logic            par_valid,
    input  logic            par_ready,
    output logic [MI-1:0]   par_idx,
    output logic [PW-1:0]   par_data
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LOAD  = 3'd2,
        S_ACC   = 3'd3,
        S_OUT   = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [KW-1:0]     k_q;
    logic [MW-1:0]     m_q;
    logic [KI-1:0]     d_q;
    logic [MI-1:0]     p_q;
    logic [PW-1:0]     acc_q;
    logic [W*W-1:0]    cols_q;
    logic [PW-1:0]     pkt_q;
    logic              cfg_err_q;

    logic cfg_ok;
    logic d_last;
    logic p_last;
    logic handshake;

    assign cfg_ok = (k_cfg >= KW'(K_MIN)) && (k_cfg <= KW'(K_MAX)) &&
                    (m_cfg >= MW'(M_MIN)) && (m_cfg <= MW'(M_MAX));
    assign d_last    = (KW'(d_q) == (k_q - KW'(1)));
    assign p_last    = (MW'(p_q) == (m_q - MW'(1)));
    assign handshake = (state_q == S_OUT) && par_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start && cfg_ok) state_d = S_FETCH;
            S_FETCH: state_d = S_LOAD;
            S_LOAD:  state_d = S_ACC;
            S_ACC:   state_d = d_last ? S_OUT : S_FETCH;
            S_OUT:   if (par_ready) state_d = p_last ? S_DONE : S_FETCH;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        done        = 1'b0;
        bm_rd_en    = 1'b0;
        data_rd_en  = 1'b0;
        bm_rd_row   = '0;
        bm_rd_col   = '0;
        data_rd_idx = '0;
        par_valid   = 1'b0;
        par_idx     = '0;
        par_data    = '0;
        case (state_q)
            S_FETCH: begin
                bm_rd_en    = 1'b1;
                data_rd_en  = 1'b1;
                bm_rd_row   = p_q;
                bm_rd_col   = d_q;
                data_rd_idx = d_q;
            end
            S_OUT: begin
                par_valid = 1'b1;
                par_idx   = p_q;
                par_data  = acc_q;
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    assign busy     = (state_q != S_IDLE);
    assign cfg_err  = cfg_err_q;
    assign mul_cols = cols_q;
    assign mul_pkt  = pkt_q;

    // Job counters, captured configuration and the multiply operand/accumulator registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_q       <= '0;
            m_q       <= '0;
            d_q       <= '0;
            p_q       <= '0;
            acc_q     <= '0;
            cols_q    <= '0;
            pkt_q     <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            cfg_err_q <= (state_q == S_IDLE) && start && !cfg_ok;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        k_q <= k_cfg;
                        m_q <= m_cfg;
                        if (cfg_ok) begin
                            d_q   <= '0;
                            p_q   <= '0;
                            acc_q <= '0;
                        end
                    end
                end
                S_LOAD: begin
                    cols_q <= bm_rd_data;
                    pkt_q  <= data_rd_data;
                end
                S_ACC: begin
                    acc_q <= acc_q ^ mul_product;
                    d_q   <= d_last ? '0 : d_q + KI'(1);
                end
                S_OUT: begin
                    if (handshake) begin
                        acc_q <= '0;
                        if (!p_last) p_q <= p_q + MI'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bm_enc_ctrl.sv
// Directed bench for bm_enc_ctrl with identity multiplier, 1-cycle stores and a parity scoreboard.
module tb_bm_enc_ctrl;

    localparam int K_MAX = 128;
    localparam int M_MAX = 128;
    localparam int W     = 4;
    localparam int PL    = 2;
    localparam int PW    = W * PL;
    localparam int WW    = W * W;
    localparam int KW    = $clog2(K_MAX + 1);
    localparam int MW    = $clog2(M_MAX + 1);
    localparam int KI    = $clog2(K_MAX);
    localparam int MI    = $clog2(M_MAX);

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            start = 1'b0;
    logic [KW-1:0]   k_cfg = '0;
    logic [MW-1:0]   m_cfg = '0;
    logic            busy, done, cfg_err;
    logic            bm_rd_en, data_rd_en;
    logic [MI-1:0]   bm_rd_row;
    logic [KI-1:0]   bm_rd_col, data_rd_idx;
    logic [WW-1:0]   bm_rd_data = '0;
    logic [PW-1:0]   data_rd_data = '0;
    logic [WW-1:0]   mul_cols;
    logic [PW-1:0]   mul_pkt, mul_product;
    logic            par_valid;
    logic            par_ready = 1'b1;
    logic [MI-1:0]   par_idx;
    logic [PW-1:0]   par_data;

    logic [PW-1:0]   data_mem [K_MAX];
    logic [MI+PW-1:0] sb_q [$];
    logic [MI+PW-1:0] sb_e;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0, start_cyc = 0, done_cyc = 0;
    int n_done = 0, n_par = 0, n_cfgerr = 0, n_busy = 0, n_rd = 0;
    int stall_left = 0, exp_col = 0, exp_row = 0;
    bit col_chk = 1'b0;
    bit held_v = 1'b0;
    logic [PW-1:0] held_data;
    logic [MI-1:0] held_idx;
    bit pv1 = 1'b0, pv2 = 1'b0;
    logic [WW-1:0] pc1, pc2;
    logic [PW-1:0] pd1, pd2;
    int bad_k [4] = '{1, 2, 129, 2};
    int bad_m [4] = '{2, 1, 2, 129};

    bm_enc_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .k_cfg        (k_cfg),
        .m_cfg        (m_cfg),
        .busy         (busy),
        .done         (done),
        .cfg_err      (cfg_err),
        .bm_rd_en     (bm_rd_en),
        .bm_rd_row    (bm_rd_row),
        .bm_rd_col    (bm_rd_col),
        .bm_rd_data   (bm_rd_data),
        .data_rd_en   (data_rd_en),
        .data_rd_idx  (data_rd_idx),
        .data_rd_data (data_rd_data),
        .mul_cols     (mul_cols),
        .mul_pkt      (mul_pkt),
        .mul_product  (mul_product),
        .par_valid    (par_valid),
        .par_ready    (par_ready),
        .par_idx      (par_idx),
        .par_data     (par_data)
    );

    always #5 clk = ~clk;

    assign mul_product = mul_pkt;

    function automatic logic [WW-1:0] bm_val(input logic [MI-1:0] r, input logic [KI-1:0] c);
        return WW'({r, c}) ^ WW'(16'hA5C3);
    endfunction

    always_ff @(posedge clk) begin
        if (bm_rd_en)   bm_rd_data   <= bm_val(bm_rd_row, bm_rd_col);
        if (data_rd_en) data_rd_data <= data_mem[data_rd_idx];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_ctrl"}, 64'({busy, done, cfg_err, bm_rd_en, data_rd_en, par_valid}), 64'd0);
        chk({tag, "_par"}, 64'({par_idx, par_data}), 64'd0);
        chk({tag, "_rd"}, 64'({bm_rd_row, bm_rd_col, data_rd_idx}), 64'd0);
        chk({tag, "_mul"}, 64'({mul_cols, mul_pkt}), 64'd0);
    endtask

    // One clock: observe at the falling edge, return 1ns after the next rising edge.
    task automatic step();
        @(negedge clk);
        if (par_valid) begin
            if (held_v) begin
                chk("par_hold_data", 64'(par_data), 64'(held_data));
                chk("par_hold_idx", 64'(par_idx), 64'(held_idx));
            end
            if (par_ready) begin
                if (sb_q.size() == 0) begin
                    chk("par_unexpected", 64'(par_valid), 64'd0);
                end else begin
                    sb_e = sb_q.pop_front();
                    chk("par_idx", 64'(par_idx), 64'(sb_e[PW +: MI]));
                    chk("par_data", 64'(par_data), 64'(sb_e[PW-1:0]));
                end
                n_par++;
                held_v = 1'b0;
            end else begin
                held_v    = 1'b1;
                held_data = par_data;
                held_idx  = par_idx;
                if (stall_left > 0) stall_left--;
            end
        end else begin
            held_v = 1'b0;
        end
        if (pv2) begin
            chk("mul_cols", 64'(mul_cols), 64'(pc2));
            chk("mul_pkt", 64'(mul_pkt), 64'(pd2));
        end
        pv2 = pv1; pc2 = pc1; pd2 = pd1;
        pv1 = bm_rd_en;
        pc1 = bm_val(bm_rd_row, bm_rd_col);
        pd1 = data_mem[data_rd_idx];
        if (bm_rd_en || data_rd_en) begin
            n_rd++;
            chk("rd_pair", 64'({bm_rd_en, data_rd_en, bm_rd_col == data_rd_idx}), 64'd7);
            if (col_chk) begin
                chk("rd_col", 64'(bm_rd_col), 64'(exp_col));
                chk("rd_row", 64'(bm_rd_row), 64'(exp_row));
                if (exp_col == K_MAX - 1) begin
                    exp_col = 0;
                    exp_row++;
                end else begin
                    exp_col++;
                end
            end
        end
        if (done) begin
            n_done++;
            done_cyc = cyc;
        end
        if (cfg_err) n_cfgerr++;
        if (busy) n_busy++;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic push_job(input int k, input int m);
        logic [PW-1:0] x;
        x = '0;
        for (int i = 0; i < k; i++) x ^= data_mem[i];
        for (int p = 0; p < m; p++) sb_q.push_back({MI'(p), x});
    endtask

    task automatic run_job(input int k, input int m, input int stall, input int pulse_at,
                           input int exp_lat);
        n_done = 0;
        n_par = 0;
        stall_left = stall;
        if (stall > 0) par_ready = 1'b0;
        start = 1'b1;
        k_cfg = KW'(k);
        m_cfg = MW'(m);
        start_cyc = cyc;
        step();
        start = 1'b0;
        k_cfg = '1;
        m_cfg = '1;
        for (int i = 0; i < 4000 && n_done == 0; i++) begin
            start = (i == pulse_at);
            if (i == pulse_at) begin
                k_cfg = KW'(2);
                m_cfg = MW'(3);
            end
            if (stall_left == 0) par_ready = 1'b1;
            step();
        end
        start = 1'b0;
        par_ready = 1'b1;
        chk("done_seen", 64'(n_done), 64'd1);
        chk("done_latency", 64'(done_cyc - start_cyc), 64'(exp_lat));
        repeat (3) step();
        chk("done_once", 64'(n_done), 64'd1);
        chk("par_count", 64'(n_par), 64'(m));
        chk("sb_drained", 64'(sb_q.size()), 64'd0);
        chk("idle_busy", 64'(busy), 64'd0);
    endtask

    initial begin
        for (int i = 0; i < K_MAX; i++) data_mem[i] = '0;
        #1 rst_n = 1'b0;
        #2 chk_idle("reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Basic two-by-two job
        data_mem[0] = 8'h3C;
        data_mem[1] = 8'h0F;
        push_job(2, 2);
        run_job(2, 2, 0, -1, 15);

        // Illegal configurations
        for (int i = 0; i < 4; i++) begin
            n_cfgerr = 0;
            n_busy = 0;
            n_rd = 0;
            start = 1'b1;
            k_cfg = KW'(bad_k[i]);
            m_cfg = MW'(bad_m[i]);
            step();
            start = 1'b0;
            repeat (3) step();
            chk("cfg_err_pulse", 64'(n_cfgerr), 64'd1);
            chk("cfg_err_busy", 64'(n_busy), 64'd0);
            chk("cfg_err_rd", 64'(n_rd), 64'd0);
        end

        // Back-pressure in the first OUT
        push_job(2, 2);
        run_job(2, 2, 5, -1, 20);

        // Start pulse with a different configuration while busy
        data_mem[2] = 8'hA5;
        push_job(3, 2);
        run_job(3, 2, 0, 4, 21);

        // Reset in the second ACC aborts the job
        data_mem[0] = 8'h5A;
        data_mem[1] = 8'hC3;
        push_job(2, 2);
        n_done = 0;
        start = 1'b1;
        k_cfg = KW'(2);
        m_cfg = MW'(2);
        step();
        start = 1'b0;
        repeat (5) step();
        chk("acc2_busy", 64'(busy), 64'd1);
        chk("acc2_pkt", 64'(mul_pkt), 64'h C3);
        #2 rst_n = 1'b0;
        #1 chk_idle("midrst");
        sb_q.delete();
        pv1 = 1'b0;
        pv2 = 1'b0;
        held_v = 1'b0;
        repeat (3) step();
        chk("abort_no_done", 64'(n_done), 64'd0);
        rst_n = 1'b1;
        push_job(2, 2);
        run_job(2, 2, 0, -1, 15);

        // Full-width job with random packets
        for (int i = 0; i < K_MAX; i++) data_mem[i] = PW'($urandom);
        col_chk = 1'b1;
        exp_col = 0;
        exp_row = 0;
        push_job(K_MAX, 2);
        run_job(K_MAX, 2, 0, -1, 2 * (3 * K_MAX + 1) + 1);
        col_chk = 1'b0;
        chk("sweep_rows", 64'(exp_row), 64'd2);
        chk("sweep_cols", 64'(exp_col), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
